// File: rtl/dvfs_supply_responder.sv
// Provider-side DVFS responder: ramps the shared core rail and switches per-domain
// clock muxes, acknowledging 4-phase vreq/clk_req once the operating point is reached.
module dvfs_supply_responder #(
  parameter int unsigned NUM_DOMAINS   = 8,
  parameter int unsigned VSTEP_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SWITCH_GAP    = 2,
  parameter int unsigned LOCK_TIMEOUT  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 global_perf_i,
  input  logic [NUM_DOMAINS-1:0]     vreq_i,
  output logic [NUM_DOMAINS-1:0]     vack_o,
  input  logic [NUM_DOMAINS-1:0]     clk_req_i,
  output logic [NUM_DOMAINS-1:0]     clk_ack_o,
  input  logic [2*NUM_DOMAINS-1:0]   clk_sel_i,
  input  logic [1:0]                 pll_lock_i,
  output logic [7:0]                 vcode_o,
  output logic [2*NUM_DOMAINS-1:0]   clk_mux_o,
  output logic [NUM_DOMAINS-1:0]     clk_gate_en_o,
  output logic [NUM_DOMAINS-1:0]     lock_err_o,
  output logic                       busy_o
);

  localparam int unsigned VMAX = (VSTEP_CYCLES > SETTLE_CYCLES) ? VSTEP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned VW   = (VMAX > 1) ? $clog2(VMAX) : 1;
  localparam int unsigned CMAX = (LOCK_TIMEOUT > SWITCH_GAP + 1) ? LOCK_TIMEOUT : SWITCH_GAP + 1;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [VW-1:0] VSTEP_LAST  = VW'(VSTEP_CYCLES - 1);
  localparam logic [VW-1:0] SETTLE_LAST = VW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SWITCH_GAP - 1);
  localparam logic [CW-1:0] GAP_END     = CW'(SWITCH_GAP);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {V_IDLE, V_RAMP, V_SETTLE} vstate_t;
  typedef enum logic [1:0] {C_IDLE, C_GATE, C_LOCK, C_ACK} cstate_t;

  function automatic logic [7:0] perf_code(input logic [2:0] perf);
    case (perf)
      3'd0:    perf_code = 8'h40;
      3'd1:    perf_code = 8'h50;
      3'd2:    perf_code = 8'h60;
      3'd3:    perf_code = 8'h70;
      default: perf_code = 8'h80;
    endcase
  endfunction

  // Rail state
  vstate_t                vst, vst_nxt;
  logic [7:0]             target, target_nxt, vcode_nxt, vcode_step, req_code;
  logic [NUM_DOMAINS-1:0] mask, mask_nxt, vack_nxt, vack_set, pending;
  logic [VW-1:0]          vcnt, vcnt_nxt;

  // Per-domain clock state
  cstate_t                  cst      [NUM_DOMAINS];
  cstate_t                  cst_nxt  [NUM_DOMAINS];
  logic [1:0]               csel     [NUM_DOMAINS];
  logic [1:0]               csel_nxt [NUM_DOMAINS];
  logic [CW-1:0]            ccnt     [NUM_DOMAINS];
  logic [CW-1:0]            ccnt_nxt [NUM_DOMAINS];
  logic [2*NUM_DOMAINS-1:0] mux_nxt;
  logic [NUM_DOMAINS-1:0]   gate_nxt, cack_nxt, err_nxt;
  logic                     cbusy;

  assign pending  = vreq_i & ~vack_o;
  assign req_code = perf_code(global_perf_i);
  assign busy_o   = (vst != V_IDLE) || cbusy;

  always_comb begin
    vst_nxt    = vst;
    vcode_nxt  = vcode_o;
    target_nxt = target;
    mask_nxt   = mask;
    vcnt_nxt   = vcnt;
    vack_set   = '0;
    vcode_step = (target > vcode_o) ? vcode_o + 8'd1 : vcode_o - 8'd1;
    case (vst)
      V_IDLE: begin
        if (|pending) begin
          mask_nxt   = pending;
          target_nxt = req_code;
          vcnt_nxt   = '0;
          if (req_code == vcode_o) vack_set = pending;
          else                     vst_nxt  = V_RAMP;
        end
      end
      V_RAMP: begin
        if (vcnt == VSTEP_LAST) begin
          vcnt_nxt  = '0;
          vcode_nxt = vcode_step;
          if (vcode_step == target) vst_nxt = V_SETTLE;
        end else begin
          vcnt_nxt = vcnt + 1'b1;
        end
      end
      V_SETTLE: begin
        if (vcnt == SETTLE_LAST) begin
          // domains that withdrew their request during the pass stay unacked
          vack_set = mask & vreq_i;
          vcnt_nxt = '0;
          vst_nxt  = V_IDLE;
        end else begin
          vcnt_nxt = vcnt + 1'b1;
        end
      end
      default: vst_nxt = V_IDLE;
    endcase
    vack_nxt = (vack_o & vreq_i) | vack_set;
  end

  always_comb begin
    cst_nxt  = cst;
    csel_nxt = csel;
    ccnt_nxt = ccnt;
    mux_nxt  = clk_mux_o;
    gate_nxt = clk_gate_en_o;
    cack_nxt = clk_ack_o;
    err_nxt  = lock_err_o;
    cbusy    = 1'b0;
    for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
      cbusy = cbusy | (cst[d] != C_IDLE);
      case (cst[d])
        C_IDLE: begin
          // clock requests wait until any voltage request for the domain is acked
          if (clk_req_i[d] && !clk_ack_o[d] && (!vreq_i[d] || vack_o[d])) begin
            if (clk_sel_i[2*d +: 2] == clk_mux_o[2*d +: 2]) begin
              cack_nxt[d] = 1'b1;
              cst_nxt[d]  = C_ACK;
            end else begin
              csel_nxt[d] = clk_sel_i[2*d +: 2];
              gate_nxt[d] = 1'b0;
              ccnt_nxt[d] = '0;
              cst_nxt[d]  = C_GATE;
            end
          end
        end
        C_GATE: begin
          if (ccnt[d] == GAP_LAST) begin
            mux_nxt[2*d +: 2] = csel[d];
            if (csel[d] == 2'd1 || csel[d] == 2'd2) begin
              ccnt_nxt[d] = '0;
              cst_nxt[d]  = C_LOCK;
            end else begin
              ccnt_nxt[d] = ccnt[d] + 1'b1;
            end
          end else if (ccnt[d] == GAP_END) begin
            gate_nxt[d] = (csel[d] == 2'd3);
            cack_nxt[d] = clk_req_i[d];
            ccnt_nxt[d] = '0;
            cst_nxt[d]  = clk_req_i[d] ? C_ACK : C_IDLE;
          end else begin
            ccnt_nxt[d] = ccnt[d] + 1'b1;
          end
        end
        C_LOCK: begin
          // sel is 1 (pllA) or 2 (pllB) here, so sel[1] picks the lock bit
          if (pll_lock_i[csel[d][1]]) begin
            gate_nxt[d] = 1'b1;
            cack_nxt[d] = clk_req_i[d];
            ccnt_nxt[d] = '0;
            cst_nxt[d]  = clk_req_i[d] ? C_ACK : C_IDLE;
          end else if (ccnt[d] == LOCK_LAST) begin
            mux_nxt[2*d +: 2] = 2'd3;
            err_nxt[d]        = 1'b1;
            gate_nxt[d]       = 1'b1;
            cack_nxt[d]       = clk_req_i[d];
            ccnt_nxt[d]       = '0;
            cst_nxt[d]        = clk_req_i[d] ? C_ACK : C_IDLE;
          end else begin
            ccnt_nxt[d] = ccnt[d] + 1'b1;
          end
        end
        C_ACK: begin
          if (!clk_req_i[d]) begin
            cack_nxt[d] = 1'b0;
            cst_nxt[d]  = C_IDLE;
          end
        end
        default: cst_nxt[d] = C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vst           <= V_IDLE;
      vcode_o       <= 8'h40;
      target        <= 8'h40;
      mask          <= '0;
      vcnt          <= '0;
      vack_o        <= '0;
      clk_mux_o     <= '0;
      clk_gate_en_o <= '0;
      clk_ack_o     <= '0;
      lock_err_o    <= '0;
      for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
        cst[d]  <= C_IDLE;
        csel[d] <= '0;
        ccnt[d] <= '0;
      end
    end else begin
      vst           <= vst_nxt;
      vcode_o       <= vcode_nxt;
      target        <= target_nxt;
      mask          <= mask_nxt;
      vcnt          <= vcnt_nxt;
      vack_o        <= vack_nxt;
      clk_mux_o     <= mux_nxt;
      clk_gate_en_o <= gate_nxt;
      clk_ack_o     <= cack_nxt;
      lock_err_o    <= err_nxt;
      for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
        cst[d]  <= cst_nxt[d];
        csel[d] <= csel_nxt[d];
        ccnt[d] <= ccnt_nxt[d];
      end
    end
  end

endmodule

// File: tb/tb_dvfs_supply_responder.sv
// Directed bench for dvfs_supply_responder: rail ramps, clock switches, lock timeout, reset.
module tb_dvfs_supply_responder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  global_perf;
  logic [7:0]  vreq, vack, clk_req, clk_ack, gate_en, lock_err;
  logic [15:0] clk_sel, clk_mux;
  logic [1:0]  pll_lock;
  logic [7:0]  vcode;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cur         = 0;

  dvfs_supply_responder #(
    .NUM_DOMAINS(8), .VSTEP_CYCLES(4), .SETTLE_CYCLES(8), .SWITCH_GAP(2), .LOCK_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .global_perf_i(global_perf),
    .vreq_i(vreq), .vack_o(vack), .clk_req_i(clk_req), .clk_ack_o(clk_ack),
    .clk_sel_i(clk_sel), .pll_lock_i(pll_lock), .vcode_o(vcode),
    .clk_mux_o(clk_mux), .clk_gate_en_o(gate_en), .lock_err_o(lock_err), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cur = last posedge passed, relative to the edge that accepted the current request
  task automatic adv_to(input int e);
    repeat (e - cur) @(negedge clk);
    cur = e;
  endtask

  task automatic start_seq();
    cur = -1;
  endtask

  initial begin
    rst_n = 1'b0; global_perf = 3'd0; vreq = '0; clk_req = '0; clk_sel = '0; pll_lock = '0;
    repeat (3) @(negedge clk);
    chk("rst_vcode", 32'(vcode), 32'h40);
    chk("rst_mux", 32'(clk_mux), 32'h0);
    chk("rst_gate", 32'(gate_en), 32'h0);
    chk("rst_vack", 32'(vack), 32'h0);
    chk("rst_cack", 32'(clk_ack), 32'h0);
    chk("rst_err", 32'(lock_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0x40 -> 0x70, then frozen-target second pass to 0x80
    global_perf = 3'd3; vreq = 8'h01; start_seq();
    adv_to(0);   chk("ramp_e0_vcode", 32'(vcode), 32'h40); chk("ramp_e0_busy", 32'(busy), 32'h1);
    adv_to(3);   chk("ramp_e3_vcode", 32'(vcode), 32'h40);
    adv_to(4);   chk("ramp_e4_vcode", 32'(vcode), 32'h41);
    adv_to(8);   chk("ramp_e8_vcode", 32'(vcode), 32'h42);
    global_perf = 3'd4; vreq = 8'h03;
    adv_to(199); chk("ramp_e199_vcode", 32'(vcode), 32'h70); chk("ramp_e199_vack", 32'(vack), 32'h00);
    adv_to(200); chk("ramp_e200_vack", 32'(vack), 32'h01); chk("ramp_e200_vcode", 32'(vcode), 32'h70);
    adv_to(264); chk("pass2_e264_vcode", 32'(vcode), 32'h7F);
    adv_to(265); chk("pass2_e265_vcode", 32'(vcode), 32'h80);
    adv_to(272); chk("pass2_e272_vack", 32'(vack), 32'h01);
    adv_to(273); chk("pass2_e273_vack", 32'(vack), 32'h03);
    vreq = 8'h02;
    adv_to(274); chk("vack0_release", 32'(vack), 32'h02);
    vreq = 8'h00;
    adv_to(275); chk("vack1_release", 32'(vack), 32'h00); chk("rail_idle_busy", 32'(busy), 32'h0);

    // Voltage-before-clock on domain 2, rail ramps down 0x80 -> 0x70
    global_perf = 3'd3; vreq = 8'h04; clk_req = 8'h04; clk_sel[5:4] = 2'd3; start_seq();
    adv_to(4);  chk("down_e4_vcode", 32'(vcode), 32'h7F);
    adv_to(71); chk("order_e71_cack", 32'(clk_ack), 32'h00); chk("order_e71_vack", 32'(vack), 32'h00);
                chk("order_e71_mux", 32'(clk_mux), 32'h0000);
    adv_to(72); chk("order_e72_vack", 32'(vack), 32'h04); chk("order_e72_vcode", 32'(vcode), 32'h70);
    adv_to(74); chk("order_e74_mux", 32'(clk_mux), 32'h0000); chk("order_e74_cack", 32'(clk_ack), 32'h00);
    adv_to(75); chk("order_e75_mux", 32'(clk_mux), 32'h0030); chk("order_e75_gate", 32'(gate_en), 32'h00);
    adv_to(76); chk("order_e76_gate", 32'(gate_en), 32'h04); chk("order_e76_cack", 32'(clk_ack), 32'h04);
    vreq = 8'h00; clk_req = 8'h00;
    adv_to(77); chk("order_release_cack", 32'(clk_ack), 32'h00); chk("order_release_vack", 32'(vack), 32'h00);

    // Domain 3 to osc, then osc -> pllA with lock 5 cycles after the mux change
    clk_req = 8'h08; clk_sel[7:6] = 2'd3; start_seq();
    adv_to(2); chk("osc3_e2_mux", 32'(clk_mux), 32'h00F0); chk("osc3_e2_cack", 32'(clk_ack), 32'h00);
    adv_to(3); chk("osc3_e3_cack", 32'(clk_ack), 32'h08); chk("osc3_e3_gate", 32'(gate_en), 32'h0C);
    clk_req = 8'h00;
    adv_to(4); chk("osc3_release", 32'(clk_ack), 32'h00);
    clk_req = 8'h08; clk_sel[7:6] = 2'd1; start_seq();
    adv_to(0); chk("plla_e0_gate", 32'(gate_en), 32'h04);
    adv_to(2); chk("plla_e2_mux", 32'(clk_mux), 32'h0070);
    adv_to(6); chk("plla_e6_cack", 32'(clk_ack), 32'h00); chk("plla_e6_gate", 32'(gate_en), 32'h04);
    pll_lock = 2'b01;
    adv_to(7); chk("plla_e7_cack", 32'(clk_ack), 32'h08); chk("plla_e7_gate", 32'(gate_en), 32'h0C);
               chk("plla_e7_err", 32'(lock_err), 32'h00);
    clk_req = 8'h00;
    adv_to(8); chk("plla_release", 32'(clk_ack), 32'h00);

    // pllB never locks (pllA lock stays high and must be ignored)
    clk_req = 8'h08; clk_sel[7:6] = 2'd2; start_seq();
    adv_to(0);  chk("pllb_e0_gate", 32'(gate_en), 32'h04);
    adv_to(2);  chk("pllb_e2_mux", 32'(clk_mux), 32'h00B0);
    adv_to(33); chk("pllb_e33_mux", 32'(clk_mux), 32'h00B0); chk("pllb_e33_cack", 32'(clk_ack), 32'h00);
                chk("pllb_e33_err", 32'(lock_err), 32'h00);
    adv_to(34); chk("tmo_e34_mux", 32'(clk_mux), 32'h00F0); chk("tmo_e34_err", 32'(lock_err), 32'h08);
                chk("tmo_e34_cack", 32'(clk_ack), 32'h08); chk("tmo_e34_gate", 32'(gate_en), 32'h0C);
    clk_req = 8'h00;
    adv_to(35); chk("tmo_release_cack", 32'(clk_ack), 32'h00); chk("tmo_err_sticky", 32'(lock_err), 32'h08);

    // Same source: domain 3 osc->osc (gated on), domain 5 off->off (gated off)
    clk_req = 8'h28; clk_sel[7:6] = 2'd3; clk_sel[11:10] = 2'd0; start_seq();
    adv_to(0); chk("same_e0_cack", 32'(clk_ack), 32'h28); chk("same_e0_gate", 32'(gate_en), 32'h0C);
               chk("same_e0_mux", 32'(clk_mux), 32'h00F0);
    clk_req = 8'h00;
    adv_to(1); chk("same_release", 32'(clk_ack), 32'h00);

    // Domain 4 request withdrawn mid-switch: switch completes, no ack
    clk_req = 8'h10; clk_sel[9:8] = 2'd3; start_seq();
    adv_to(1); clk_req = 8'h00;
    adv_to(2); chk("drop_e2_mux", 32'(clk_mux), 32'h03F0); chk("drop_e2_gate", 32'(gate_en), 32'h0C);
    adv_to(3); chk("drop_e3_gate", 32'(gate_en), 32'h1C); chk("drop_e3_cack", 32'(clk_ack), 32'h00);
               chk("drop_e3_busy", 32'(busy), 32'h0);

    // Reset during a ramp (0x70 -> 0x80) and a pllA switch on domain 6
    global_perf = 3'd4; vreq = 8'h01; pll_lock = 2'b00; clk_req = 8'h40; clk_sel[13:12] = 2'd1;
    start_seq();
    adv_to(10); chk("mid_e10_vcode", 32'(vcode), 32'h72); chk("mid_e10_mux", 32'(clk_mux), 32'h13F0);
                chk("mid_e10_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_vcode", 32'(vcode), 32'h40);
    chk("arst_mux", 32'(clk_mux), 32'h0);
    chk("arst_gate", 32'(gate_en), 32'h0);
    chk("arst_err", 32'(lock_err), 32'h0);
    chk("arst_vack", 32'(vack), 32'h0);
    chk("arst_cack", 32'(clk_ack), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    vreq = '0; clk_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
